// File: rtl/usb_fs_rx_recovery.sv
// usb_fs_rx_recovery: full-speed D+/D- line-state recovery, mid-bit sampling and bus-reset detect
`timescale 1ns/1ps
module usb_fs_rx_recovery #(
  parameter int SYNC_STAGES  = 2,
  parameter int OVERSAMPLE   = 4,
  parameter int RESET_CYCLES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dp_rx,
  input  logic       dn_rx,
  input  logic       rx_en,
  output logic [1:0] line_state,
  output logic       sample_valid,
  output logic [1:0] sample_state,
  output logic       bus_reset
);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(RESET_CYCLES + 1);
  localparam logic [PW-1:0] PH_HALF = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] PH_LAST = PW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RESET_CYCLES);
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] J   = 2'b01;
  logic [SYNC_STAGES-1:0] dp_sync_q, dp_sync_d, dn_sync_q, dn_sync_d;
  logic [1:0] s, dec_q, dec_d, ls_q, ls_d, ss_q, ss_d;
  logic sv_q, sv_d, br_q, br_d, ls_edge, strobe;
  logic [PW-1:0] ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // next state: sync, two-sample glitch filter, phase tracking, SE0 timing
  always_comb begin
    dp_sync_d = {dp_sync_q[SYNC_STAGES-2:0], dp_rx};
    dn_sync_d = {dn_sync_q[SYNC_STAGES-2:0], dn_rx};
    s         = {dn_sync_q[SYNC_STAGES-1], dp_sync_q[SYNC_STAGES-1]};
    dec_d     = s;
    ls_d      = (s == dec_q) ? dec_q : ls_q;
    ls_edge   = ls_d != ls_q;
    strobe    = rx_en && !ls_edge && ph_q == PH_HALF;
    ph_d      = !rx_en ? '0 : ls_edge ? PW'(1) : (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    sv_d      = strobe;
    ss_d      = strobe ? ls_q : ss_q;
    cnt_d     = (ls_d != SE0) ? '0 : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    br_d      = cnt_q == CNT_MAX;
  end
  // state registers, all outputs come straight from here
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_sync_q <= '1;
      dn_sync_q <= '0;
      dec_q     <= J;
      ls_q      <= J;
      ss_q      <= J;
      sv_q      <= 1'b0;
      br_q      <= 1'b0;
      ph_q      <= '0;
      cnt_q     <= '0;
    end else begin
      dp_sync_q <= dp_sync_d;
      dn_sync_q <= dn_sync_d;
      dec_q     <= dec_d;
      ls_q      <= ls_d;
      ss_q      <= ss_d;
      sv_q      <= sv_d;
      br_q      <= br_d;
      ph_q      <= ph_d;
      cnt_q     <= cnt_d;
    end
  end
  assign line_state   = ls_q;
  assign sample_valid = sv_q;
  assign sample_state = ss_q;
  assign bus_reset    = br_q;
endmodule

// File: tb/tb_usb_fs_rx_recovery.sv
// tb_usb_fs_rx_recovery: randomized J/K streams, glitches, SE0/SE1 and rx_en gating against a bit-level model
`timescale 1ns/1ps
module tb_usb_fs_rx_recovery;
  localparam int SS  = 2;
  localparam int OS  = 4;
  localparam int RC  = 120;
  localparam int LAT = SS + 2;
  localparam int NL  = 4096;
  logic clk = 1'b0, rst = 1'b1, dp_rx = 1'b1, dn_rx = 1'b0, rx_en = 1'b0;
  logic [1:0] line_state, sample_state;
  logic sample_valid, bus_reset;
  int total = 0, bad = 0, cyc = 0;
  int k0, k1;
  logic [1:0] cur = 2'b01;
  logic [1:0] exp_q[$];
  logic [1:0] ls_log[NL], ss_log[NL];
  logic sv_log[NL], br_log[NL];
  usb_fs_rx_recovery #(.SYNC_STAGES(SS), .OVERSAMPLE(OS), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .dp_rx(dp_rx), .dn_rx(dn_rx), .rx_en(rx_en),
    .line_state(line_state), .sample_valid(sample_valid),
    .sample_state(sample_state), .bus_reset(bus_reset)
  );
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < NL) begin
    ls_log[cyc] = line_state;
    ss_log[cyc] = sample_state;
    sv_log[cyc] = sample_valid;
    br_log[cyc] = bus_reset;
  end
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
    end
  endtask
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(logic [1:0] l);
    dp_rx = l[0];
    dn_rx = l[1];
    cur = l;
  endtask
  function automatic logic [1:0] other(logic [1:0] l);
    return (l == 2'b01) ? 2'b10 : 2'b01;
  endfunction
  task automatic send(int n, int drift);
    int run = 0;
    logic [1:0] l;
    exp_q.delete();
    k0 = cyc;
    for (int i = 0; i < n; i++) begin
      l = (i == 0 || run == 6) ? other(cur) : ($urandom_range(0, 1) ? 2'b01 : 2'b10);
      run = (i > 0 && l == cur) ? run + 1 : 1;
      drive(l);
      exp_q.push_back(l);
      step(OS + ((i % 7 == 6) ? drift : 0));
    end
    k1 = cyc;
  endtask
  task automatic scan(string tag, bit en);
    int n = 0;
    for (int c = k0 + LAT; c < k1 + LAT; c++) if (sv_log[c]) begin
      if (en && n < exp_q.size()) chk(tag, ss_log[c], exp_q[n]);
      n++;
    end
    chk({tag, "_cnt"}, n, en ? exp_q.size() : 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end
  initial begin
    int k, d, n, e0, x;
    drive(2'b01);
    step(3);
    rst = 1'b0;
    chk("rst_ls", line_state, 1);
    chk("rst_sv", sample_valid, 0);
    chk("rst_ss", sample_state, 1);
    chk("rst_br", bus_reset, 0);
    step(21);
    n = 0;
    for (int c = cyc - 20; c < cyc; c++) n += sv_log[c];
    chk("idle_strobes", n, 0);
    rx_en = 1'b1;
    step(10);
    k = cyc;
    drive(2'b10);
    step(20);
    d = k + LAT;
    chk("step_ls_pre", ls_log[d-1], 1);
    chk("step_ls", ls_log[d], 2);
    for (int c = d; c < d + 3 * OS; c++) begin
      chk("step_sv", sv_log[c], (c - d) % OS == OS / 2);
      if ((c - d) % OS == OS / 2) chk("step_ss", ss_log[c], 2);
    end
    k = cyc;
    drive(2'b01);
    step(10);
    drive(2'b10);
    step(1);
    drive(2'b01);
    step(30);
    d = k + LAT;
    for (int c = d; c < d + 36; c++) begin
      chk("glitch_ls", ls_log[c], 1);
      chk("glitch_sv", sv_log[c], (c - d) % OS == OS / 2);
    end
    k = cyc;
    drive(2'b11);
    step(12);
    drive(2'b01);
    step(10);
    d = k + LAT;
    chk("se1_ls", ls_log[d], 3);
    chk("se1_sv", sv_log[d+OS/2], 1);
    chk("se1_ss", ss_log[d+OS/2], 3);
    chk("se1_br", br_log[d+8], 0);
    step(8);
    send(64, 1);
    step(LAT + 1);
    scan("drift_plus", 1);
    send(64, -1);
    step(LAT + 1);
    scan("drift_minus", 1);
    rx_en = 1'b0;
    drive(2'b01);
    step(8);
    k = cyc;
    drive(2'b00);
    step(RC - 1);
    drive(2'b01);
    step(20);
    n = 0;
    for (int c = k; c < cyc; c++) n += br_log[c];
    chk("se0_short_br", n, 0);
    chk("se0_short_ls", ls_log[k+LAT], 0);
    k = cyc;
    drive(2'b00);
    step(140);
    drive(2'b01);
    step(20);
    e0 = k + LAT;
    x = k + 140 + LAT;
    for (int c = k; c < cyc; c++) chk("se0_long_br", br_log[c], c >= e0 + RC && c <= x);
    rx_en = 1'b1;
    step(8);
    send(16, 0);
    step(LAT + 1);
    scan("en_a", 1);
    rx_en = 1'b0;
    send(10, 0);
    step(LAT + 1);
    scan("en_off", 0);
    rx_en = 1'b1;
    send(16, 0);
    step(LAT + 1);
    scan("en_resume", 1);
    drive(2'b10);
    step(12);
    chk("pre_rst_ss", sample_state, 2);
    rst = 1'b1;
    step(1);
    chk("mid_rst_ls", line_state, 1);
    chk("mid_rst_sv", sample_valid, 0);
    chk("mid_rst_ss", sample_state, 1);
    chk("mid_rst_br", bus_reset, 0);
    rst = 1'b0;
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
